fbuf_writer: RTL and testbench
==============================

// Module: fbuf_writer
// PURPOSE
//  Moves camera pixels from the camera output FIFO into the display frame buffer write port.
//  Sits directly downstream of the camera block's output buffer and upstream of the frame buffer BRAM.
//  Reads in fixed-length bursts gated by the FIFO almost-empty flag.
//  Generates sequential write addresses that wrap per frame, and supports a pipeline flush that re-aligns to address 0.
// PARAMETERS
//  DATA_WIDTH   16      pixel width (FIFO read data and BRAM write data)
//  BRAM_DEPTH   230400  frame buffer depth in pixels; write address wraps at BRAM_DEPTH-1
//  ADDR_WIDTH   18      write address width; must satisfy 2**ADDR_WIDTH >= BRAM_DEPTH
//  BURST_LEN    8       FIFO words read per burst; FIFO almost-empty threshold must be >= BURST_LEN
// PORTS
//  i_clk          in   1           system clock (125 MHz); the only clock
//  i_rst          in   1           asynchronous, active-high reset
//  i_flush        in   1           single-cycle request: realign frame buffer to address 0
//  o_rd           out  1           FIFO read strobe
//  i_rdata        in   DATA_WIDTH  FIFO read data, valid the cycle after o_rd
//  i_almostempty  in   1           FIFO holds fewer than threshold words
//  o_we           out  1           frame buffer write enable
//  o_waddr        out  ADDR_WIDTH  frame buffer write address
//  o_wdata        out  DATA_WIDTH  frame buffer write data
//  o_frame_done   out  1           1-cycle pulse on the write to address BRAM_DEPTH-1
//  o_frame_cnt    out  8           completed-frame counter, wraps 255->0
//  o_busy         out  1           high whenever state != IDLE or a write is pending
// BEHAVIOUR
//  Reset (async assert, sync deassert externally):
//  - state=IDLE; o_rd, o_we, o_frame_done = 0.
//  - o_waddr, o_wdata, o_frame_cnt = 0; burst counter = 0; flush_pending = 0.
//  FSM states: IDLE, READ, FLUSH.
//  - IDLE: if i_flush or flush_pending -> FLUSH.
//    Else if !i_almostempty -> READ, burst counter cleared.
//    i_almostempty is sampled only in IDLE.
//  - READ: o_rd=1 for exactly BURST_LEN consecutive cycles, then -> IDLE.
//    A burst is never truncated.
//    i_flush seen in READ sets flush_pending.
//  - FLUSH: lasts one cycle with o_rd=0.
//    Clears write address, clears flush_pending -> IDLE.
//    o_frame_cnt is not changed by a flush.
//  - Minimum spacing between bursts is 1 cycle (the IDLE cycle).
//  Write pipeline (registered; latency 1 cycle from o_rd to o_we):
//  - rd_q <= o_rd.
//  - When rd_q: o_we=1, o_wdata=i_rdata, o_waddr=current address.
//    Address then increments, or goes to 0 if it equals BRAM_DEPTH-1.
//  - o_frame_done=1 in the same cycle as the write to BRAM_DEPTH-1.
//    o_frame_cnt increments by 1 on that cycle, mod 256.
//  - o_we=0 when rd_q=0; o_waddr/o_wdata hold their last values.
//  Simultaneous events:
//  - Last burst write landing in the FLUSH cycle is performed at its old address.
//    The address clear wins over the increment, so the next write goes to 0.
//  - i_flush in FLUSH or in the IDLE cycle that enters FLUSH is absorbed (single flush).
//  - Reset mid-burst aborts immediately; no further o_rd or o_we until a new burst.
//  No arithmetic overflow beyond the explicit wraps; all counters are unsigned.
// TESTING (BURST_LEN=4, BRAM_DEPTH=8)
//  1. Reset, hold i_almostempty=1 for 20 cycles -> o_rd and o_we stay 0; o_busy=0; all outputs 0.
//  2. Deassert i_almostempty, FIFO data 0x0001..0x0004 ->
//     o_rd high for 4 cycles; o_we high 1 cycle later for 4 cycles;
//     o_waddr 0..3 with o_wdata 0x0001..0x0004.
//  3. Keep FIFO non-empty for 16 words -> o_waddr 0..7, 0..7 with bursts separated by 1 IDLE cycle;
//     o_frame_done pulses at both addr-7 writes; o_frame_cnt=2.
//  4. Pulse i_flush on the 2nd cycle of a burst starting at addr 4 ->
//     burst completes (writes 4..7, frame_done once);
//     FLUSH follows; next burst writes from addr 0.
//  5. Assert i_rst on the 3rd cycle of a burst ->
//     o_rd/o_we drop the same cycle; after release o_waddr=0, o_frame_cnt=0.
//  6. Run 256 frames -> o_frame_cnt wraps to 0 on the 256th o_frame_done.

Source files
------------

// File: rtl/fbuf_writer.sv
// Camera FIFO to frame buffer writer: burst reads gated by almost-empty,
// per-frame wrapping write address, and a flush that realigns writes to address 0.
`timescale 1ns/1ps
module fbuf_writer #(
   parameter int DATA_WIDTH = 16,
   parameter int BRAM_DEPTH = 230400,
   parameter int ADDR_WIDTH = 18,
   parameter int BURST_LEN  = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_flush,
   output logic                  o_rd,
   input  logic [DATA_WIDTH-1:0] i_rdata,
   input  logic                  i_almostempty,
   output logic                  o_we,
   output logic [ADDR_WIDTH-1:0] o_waddr,
   output logic [DATA_WIDTH-1:0] o_wdata,
   output logic                  o_frame_done,
   output logic [7:0]            o_frame_cnt,
   output logic                  o_busy
);

   localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BCW-1:0]        BURST_LAST = BCW'(BURST_LEN - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(BRAM_DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH} state_t;

   state_t                  state, state_nxt;
   logic [BCW-1:0]          burst_cnt, burst_cnt_nxt;
   logic                    flush_pend, flush_pend_nxt;
   logic                    addr_clr;
   logic                    rd_q;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [ADDR_WIDTH-1:0]   waddr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [7:0]              frame_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= S_IDLE;
         burst_cnt  <= '0;
         flush_pend <= 1'b0;
      end else begin
         state      <= state_nxt;
         burst_cnt  <= burst_cnt_nxt;
         flush_pend <= flush_pend_nxt;
      end
   end

   // A flush arriving mid-burst is deferred so the burst always completes.
   always_comb begin
      state_nxt      = state;
      burst_cnt_nxt  = burst_cnt;
      flush_pend_nxt = flush_pend;
      o_rd           = 1'b0;
      addr_clr       = 1'b0;
      case (state)
         S_IDLE: begin
            burst_cnt_nxt = '0;
            if (i_flush || flush_pend)
               state_nxt = S_FLUSH;
            else if (!i_almostempty)
               state_nxt = S_READ;
         end
         S_READ: begin
            o_rd = 1'b1;
            if (i_flush)
               flush_pend_nxt = 1'b1;
            if (burst_cnt == BURST_LAST)
               state_nxt = S_IDLE;
            else
               burst_cnt_nxt = burst_cnt + 1'b1;
         end
         S_FLUSH: begin
            addr_clr       = 1'b1;
            flush_pend_nxt = 1'b0;
            state_nxt      = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // FIFO data arrives the cycle after the strobe, so the write is issued
   // directly from rd_q; the held registers keep the last write visible.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rd_q      <= 1'b0;
         addr      <= '0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         frame_cnt <= '0;
      end else begin
         rd_q <= o_rd;
         if (rd_q) begin
            waddr_q <= addr;
            wdata_q <= i_rdata;
            if (addr == ADDR_LAST)
               frame_cnt <= frame_cnt + 8'd1;
         end
         if (addr_clr)
            addr <= '0;
         else if (rd_q)
            addr <= (addr == ADDR_LAST) ? '0 : addr + 1'b1;
      end
   end

   assign o_we         = rd_q;
   assign o_waddr      = rd_q ? addr : waddr_q;
   assign o_wdata      = rd_q ? i_rdata : wdata_q;
   assign o_frame_done = rd_q && (addr == ADDR_LAST);
   assign o_frame_cnt  = frame_cnt;
   assign o_busy       = (state != S_IDLE) || rd_q;

endmodule

// File: tb/tb_fbuf_writer.sv
// Scoreboard bench for fbuf_writer: FIFO model feeds the DUT, expected writes
// are queued on each FIFO pop and compared when the DUT writes.
`timescale 1ns/1ps
module tb_fbuf_writer;
   localparam int DW = 16, DEPTH = 8, AW = 3, BL = 4;

   logic          i_clk = 1'b0;
   logic          i_rst, i_flush, o_rd, o_we, o_frame_done, o_busy;
   logic          i_almostempty = 1'b1;
   logic [DW-1:0] i_rdata = '0;
   logic [DW-1:0] o_wdata;
   logic [AW-1:0] o_waddr;
   logic [7:0]    o_frame_cnt;

   int checks = 0, errors = 0;

   always #5 i_clk = ~i_clk;

   fbuf_writer #(.DATA_WIDTH(DW), .BRAM_DEPTH(DEPTH), .ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .o_rd(o_rd), .i_rdata(i_rdata),
      .i_almostempty(i_almostempty), .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata),
      .o_frame_done(o_frame_done), .o_frame_cnt(o_frame_cnt), .o_busy(o_busy));

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          done;
      logic [7:0]    fcnt;
   } exp_t;

   typedef struct {
      int            n;
      logic [DW-1:0] base;
      logic [AW-1:0] last;
      logic [7:0]    frames;
      int            gap;
   } vec_t;

   exp_t          exp_q[$];
   exp_t          e_cur;
   logic [DW-1:0] fifo[$];
   logic [AW-1:0] m_addr = '0;
   logic [7:0]    m_fcnt = '0;
   bit            m_flush = 0;
   bit            rd_n = 0, start_n = 0, rd_prev = 0;
   int            blen = 0, gap = -1, max_gap = 0, done_cnt = 0;
   vec_t          vt[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic load(input int n, input logic [DW-1:0] base);
      for (int i = 0; i < n; i++) fifo.push_back(base + DW'(i));
   endtask

   task automatic wait_rd(input string name);
      int i;
      for (i = 0; i < 50; i++) begin
         @(negedge i_clk);
         if (o_rd) break;
      end
      chk({name, "_rd_timeout"}, (i < 50), 1);
   endtask

   task automatic wait_idle(input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         @(negedge i_clk);
         if (fifo.size() == 0 && exp_q.size() == 0 && !rd_n) break;
      end
      chk("drain_timeout", (i < budget), 1);
      repeat (3) @(negedge i_clk);
      chk("idle_busy", o_busy, 0);
      chk("idle_we", o_we, 0);
   endtask

   // FIFO model: pop on the edge after a strobe, data valid one cycle later
   always @(posedge i_clk) begin
      #1;
      if (rd_n) begin
         chk("fifo_avail", (fifo.size() != 0), 1);
         if (fifo.size() != 0) begin
            i_rdata = fifo.pop_front();
            if (start_n && m_flush) begin
               m_addr  = '0;
               m_flush = 0;
            end
            exp_q.push_back('{m_addr, i_rdata, (m_addr == AW'(DEPTH - 1)), m_fcnt});
            if (m_addr == AW'(DEPTH - 1)) begin
               m_addr = '0;
               m_fcnt = m_fcnt + 8'd1;
            end else begin
               m_addr = m_addr + 1'b1;
            end
         end
      end
      i_almostempty = (fifo.size() < BL);
   end

   // Output monitor: write scoreboard, write latency, burst length, inter-burst gap
   always @(negedge i_clk) begin
      if (i_rst) begin
         rd_prev = 0;
         rd_n    = 0;
         start_n = 0;
         blen    = 0;
      end else begin
         start_n = o_rd && !rd_prev;
         rd_n    = o_rd;
         if (o_we || rd_prev) chk("we_latency", o_we, rd_prev);
         if (o_we) begin
            chk("write_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e_cur = exp_q.pop_front();
               chk("waddr", o_waddr, e_cur.addr);
               chk("wdata", o_wdata, e_cur.data);
               chk("frame_done", o_frame_done, e_cur.done);
               chk("frame_cnt", o_frame_cnt, e_cur.fcnt);
               if (o_frame_done) done_cnt++;
            end
         end else if (o_frame_done) begin
            chk("done_without_we", o_frame_done, 0);
         end
         if (o_rd) blen++;
         else if (rd_prev) begin
            chk("burst_len", blen, BL);
            blen = 0;
         end
         if (start_n && gap >= 0 && gap > max_gap) max_gap = gap;
         if (!o_rd) begin
            if (rd_prev) gap = 1;
            else if (gap >= 0) gap++;
         end
         rd_prev = o_rd;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running expected=finished");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{n: 4,  base: 16'h0001, last: 3'd3, frames: 8'd0, gap: 0};
      vt[1] = '{n: 4,  base: 16'h0011, last: 3'd7, frames: 8'd1, gap: 0};
      vt[2] = '{n: 16, base: 16'h0100, last: 3'd7, frames: 8'd3, gap: 1};
      vt[3] = '{n: 12, base: 16'h0200, last: 3'd3, frames: 8'd4, gap: 1};

      i_rst = 1'b1;
      i_flush = 1'b0;
      repeat (2) @(negedge i_clk);
      chk("rst_rd", o_rd, 0);
      chk("rst_we", o_we, 0);
      chk("rst_waddr", o_waddr, 0);
      chk("rst_wdata", o_wdata, 0);
      chk("rst_fcnt", o_frame_cnt, 0);
      chk("rst_done", o_frame_done, 0);
      chk("rst_busy", o_busy, 0);
      i_rst = 1'b0;

      // Quiet with FIFO almost empty
      begin
         int bad = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (o_rd || o_we || o_busy || o_frame_done) bad++;
         end
         chk("quiet_activity", bad, 0);
         chk("quiet_waddr", o_waddr, 0);
         chk("quiet_fcnt", o_frame_cnt, 0);
      end

      for (int v = 0; v < 4; v++) begin
         gap = -1;
         max_gap = 0;
         load(vt[v].n, vt[v].base);
         wait_idle(300);
         chk($sformatf("vec%0d_last_addr", v), o_waddr, vt[v].last);
         chk($sformatf("vec%0d_frames", v), o_frame_cnt, vt[v].frames);
         chk($sformatf("vec%0d_gap", v), max_gap, vt[v].gap);
      end

      // Flush during a burst starting at address 4
      done_cnt = 0;
      load(4, 16'h0400);
      wait_rd("flush_mid");
      @(negedge i_clk);
      i_flush = 1'b1;
      m_flush = 1;
      @(negedge i_clk);
      i_flush = 1'b0;
      wait_idle(100);
      chk("flush_mid_last", o_waddr, 7);
      chk("flush_mid_done", done_cnt, 1);
      chk("flush_mid_frames", o_frame_cnt, 5);
      load(4, 16'h0500);
      wait_idle(100);
      chk("after_flush_last", o_waddr, 3);
      chk("after_flush_frames", o_frame_cnt, 5);

      // Flush held across the IDLE and FLUSH cycles counts once
      @(negedge i_clk);
      i_flush = 1'b1;
      m_flush = 1;
      @(negedge i_clk);
      @(negedge i_clk);
      i_flush = 1'b0;
      load(4, 16'h0600);
      @(negedge i_clk);
      @(negedge i_clk);
      chk("absorbed_flush_rd", o_rd, 1);
      wait_idle(100);
      chk("absorbed_last", o_waddr, 3);
      chk("absorbed_frames", o_frame_cnt, 5);

      // Reset on the third cycle of a burst
      load(8, 16'h0700);
      wait_rd("reset_mid");
      @(negedge i_clk);
      @(negedge i_clk);
      #2;
      i_rst = 1'b1;
      rd_n = 0;
      #1;
      chk("rstmid_rd", o_rd, 0);
      chk("rstmid_we", o_we, 0);
      fifo.delete();
      exp_q.delete();
      m_addr = '0;
      m_fcnt = '0;
      m_flush = 0;
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
      chk("rstmid_waddr", o_waddr, 0);
      chk("rstmid_fcnt", o_frame_cnt, 0);
      chk("rstmid_busy", o_busy, 0);
      begin
         int bad = 0;
         for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            if (o_rd || o_we) bad++;
         end
         chk("rstmid_quiet", bad, 0);
      end

      // 256 frames wrap the frame counter
      done_cnt = 0;
      load(256 * DEPTH, 16'h0000);
      wait_idle(6000);
      chk("wrap_done_cnt", done_cnt, 256);
      chk("wrap_fcnt", o_frame_cnt, 0);
      chk("wrap_last", o_waddr, 7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
